issue_ctrl: RTL and testbench

ISSUE_CTRL -- requirements
Module: issue_ctrl

---
 rtl/issue_ctrl_pkg.sv | 37 +++
 rtl/issue_ctrl_operand_check.sv | 42 ++++
 rtl/issue_ctrl.sv | 139 +++++++++++++
 tb/tb_issue_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/issue_ctrl_pkg.sv
// Shared types for the dual-issue controller: scoreboard entries, latency classes and
// operand forwarding selects.
package issue_ctrl_pkg;

  localparam int unsigned RegAddrW = 5;

  typedef logic [RegAddrW-1:0] reg_addr_t;

  typedef enum logic [1:0] {
    LatAlu  = 2'd0,
    LatLoad = 2'd1,
    LatLong = 2'd2
  } lat_class_e;

  typedef enum logic [1:0] {
    FwdRf  = 2'd0,
    FwdMem = 2'd1,
    FwdWb  = 2'd2
  } fwd_sel_e;

  // position is one-hot: 100 = EX, 010 = MEM, 001 = WB, 000 = no producer in flight
  typedef struct packed {
    logic [2:0] position;
    lat_class_e lat;
  } sb_data_t;

  typedef enum logic [0:0] {
    StRun      = 1'b0,
    StLongWait = 1'b1
  } state_e;

  localparam logic [2:0] PosEx  = 3'b100;
  localparam logic [2:0] PosMem = 3'b010;
  localparam logic [2:0] PosWb  = 3'b001;
  localparam logic [2:0] PosNone = 3'b000;

endpackage

// File: rtl/issue_ctrl_operand_check.sv
// Readiness and forwarding source for one source operand, from its scoreboard entry and
// the outstanding long-latency destination.
module issue_ctrl_operand_check
  import issue_ctrl_pkg::*;
(
  input  logic      used,
  input  reg_addr_t addr,
  input  sb_data_t  entry,
  input  logic      long_wait,
  input  reg_addr_t long_dst,
  output logic      ready,
  output fwd_sel_e  fwd_sel
);

  always_comb begin
    ready   = 1'b0;
    fwd_sel = FwdRf;
    if (!used || addr == '0) begin
      ready = 1'b1;
    end else if (long_wait && addr == long_dst) begin
      ready = 1'b0;
    end else begin
      case (entry.position)
        PosNone, PosWb: ready = 1'b1;
        PosEx: begin
          if (entry.lat == LatAlu) begin
            ready   = 1'b1;
            fwd_sel = FwdMem;
          end
        end
        PosMem: begin
          if (entry.lat == LatAlu || entry.lat == LatLoad) begin
            ready   = 1'b1;
            fwd_sel = FwdWb;
          end
        end
        default: ready = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/issue_ctrl.sv
// Dual-slot in-order issue control: operand hazard checks against an external scoreboard,
// single outstanding long-latency op tracking, and a saturating hazard-stall counter.
module issue_ctrl
  import issue_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flash,
  input  logic                   pipe_stall,
  input  logic [1:0]             inst_valid,
  input  reg_addr_t [3:0]        src_addr,
  input  logic [3:0]             src_used,
  input  logic [1:0]             dst_ena,
  input  reg_addr_t [1:0]        dst_addr,
  input  lat_class_e [1:0]       lat_class,
  input  logic                   long_done,
  output reg_addr_t [3:0]        sb_read_addr,
  input  sb_data_t [3:0]         sb_data,
  output logic [1:0]             sb_write_ena,
  output reg_addr_t [1:0]        sb_write_addr,
  output sb_data_t [1:0]         sb_write_data,
  output logic [1:0]             issue_ena,
  output logic                   decode_stall,
  output fwd_sel_e [3:0]         fwd_sel,
  output logic [CNT_W-1:0]       hazard_cnt
);

  state_e           state_q;
  reg_addr_t        long_dst_q;
  logic             done_pending_q;
  logic [CNT_W-1:0] hazard_cnt_q;

  logic             long_wait;
  logic [3:0]       op_ready;
  fwd_sel_e [3:0]   op_fwd;
  logic [1:0]       dst_live;
  logic [1:0]       is_long;
  logic             dep1;
  logic             long_issue;
  reg_addr_t        long_dst_d;
  logic             hazard_hit;

  assign long_wait    = (state_q == StLongWait);
  assign sb_read_addr = src_addr;

  for (genvar i = 0; i < 4; i++) begin : g_op
    issue_ctrl_operand_check u_check (
      .used      (src_used[i]),
      .addr      (src_addr[i]),
      .entry     (sb_data[i]),
      .long_wait (long_wait),
      .long_dst  (long_dst_q),
      .ready     (op_ready[i]),
      .fwd_sel   (op_fwd[i])
    );
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      dst_live[i] = dst_ena[i] && (dst_addr[i] != '0);
      is_long[i]  = (lat_class[i] == LatLong);
    end

    // Intra-pair RAW: slot1 cannot see slot0's result in the same cycle.
    dep1 = dst_live[0] &&
           ((src_used[2] && src_addr[2] == dst_addr[0]) ||
            (src_used[3] && src_addr[3] == dst_addr[0]));

    issue_ena[0] = rst_n && inst_valid[0] && op_ready[0] && op_ready[1] &&
                   !pipe_stall && !flash && !(is_long[0] && long_wait);
    issue_ena[1] = issue_ena[0] && inst_valid[1] && op_ready[2] && op_ready[3] && !dep1 &&
                   !(is_long[0] && is_long[1]) && !(is_long[1] && long_wait);

    decode_stall = inst_valid[0] && !issue_ena[0];

    for (int i = 0; i < 2; i++) begin
      sb_write_ena[i]           = issue_ena[i] && dst_live[i];
      sb_write_addr[i]          = dst_addr[i];
      sb_write_data[i].position = PosEx;
      sb_write_data[i].lat      = lat_class[i];
    end

    for (int i = 0; i < 4; i++) begin
      fwd_sel[i] = rst_n ? op_fwd[i] : FwdRf;
    end

    long_issue = (issue_ena[0] && is_long[0]) || (issue_ena[1] && is_long[1]);
    if (issue_ena[0] && is_long[0]) begin
      long_dst_d = dst_live[0] ? dst_addr[0] : '0;
    end else begin
      long_dst_d = dst_live[1] ? dst_addr[1] : '0;
    end

    hazard_hit = inst_valid[0] && !pipe_stall && !flash && !issue_ena[0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= StRun;
      long_dst_q     <= '0;
      done_pending_q <= 1'b0;
      hazard_cnt_q   <= '0;
    end else begin
      if (flash) begin
        state_q        <= StRun;
        done_pending_q <= 1'b0;
      end else begin
        case (state_q)
          StRun: begin
            // A long_done seen here has no outstanding op to retire.
            done_pending_q <= 1'b0;
            if (long_issue) begin
              state_q    <= StLongWait;
              long_dst_q <= long_dst_d;
            end
          end
          StLongWait: begin
            if (pipe_stall) begin
              if (long_done) done_pending_q <= 1'b1;
            end else if (long_done || done_pending_q) begin
              state_q        <= StRun;
              done_pending_q <= 1'b0;
            end
          end
          default: state_q <= StRun;
        endcase
      end

      if (hazard_hit && hazard_cnt_q != '1) begin
        hazard_cnt_q <= hazard_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign hazard_cnt = hazard_cnt_q;

endmodule

// File: tb/tb_issue_ctrl.sv
// Directed checks of issue_ctrl: hazards, forwarding, long-op wait, flush and counter
// saturation, with hand-computed expectations.
module tb_issue_ctrl;
  import issue_ctrl_pkg::*;

  localparam int unsigned CntW = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flash;
  logic             pipe_stall;
  logic [1:0]       inst_valid;
  reg_addr_t [3:0]  src_addr;
  logic [3:0]       src_used;
  logic [1:0]       dst_ena;
  reg_addr_t [1:0]  dst_addr;
  lat_class_e [1:0] lat_class;
  logic             long_done;
  reg_addr_t [3:0]  sb_read_addr;
  sb_data_t [3:0]   sb_data;
  logic [1:0]       sb_write_ena;
  reg_addr_t [1:0]  sb_write_addr;
  sb_data_t [1:0]   sb_write_data;
  logic [1:0]       issue_ena;
  logic             decode_stall;
  fwd_sel_e [3:0]   fwd_sel;
  logic [CntW-1:0]  hazard_cnt;

  int n_cmp = 0;
  int n_err = 0;

  // Minimal external scoreboard: slot1 write lands last and wins.
  sb_data_t sb_mem [32];

  issue_ctrl #(.CNT_W(CntW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flash         (flash),
    .pipe_stall    (pipe_stall),
    .inst_valid    (inst_valid),
    .src_addr      (src_addr),
    .src_used      (src_used),
    .dst_ena       (dst_ena),
    .dst_addr      (dst_addr),
    .lat_class     (lat_class),
    .long_done     (long_done),
    .sb_read_addr  (sb_read_addr),
    .sb_data       (sb_data),
    .sb_write_ena  (sb_write_ena),
    .sb_write_addr (sb_write_addr),
    .sb_write_data (sb_write_data),
    .issue_ena     (issue_ena),
    .decode_stall  (decode_stall),
    .fwd_sel       (fwd_sel),
    .hazard_cnt    (hazard_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) sb_mem[i] <= '{position: 3'b000, lat: LatAlu};
    end else begin
      if (sb_write_ena[0]) sb_mem[sb_write_addr[0]] <= sb_write_data[0];
      if (sb_write_ena[1]) sb_mem[sb_write_addr[1]] <= sb_write_data[1];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_idle();
    flash      = 1'b0;
    pipe_stall = 1'b0;
    long_done  = 1'b0;
    inst_valid = 2'b00;
    src_used   = 4'b0000;
    dst_ena    = 2'b00;
    for (int i = 0; i < 4; i++) begin
      src_addr[i] = '0;
      sb_data[i]  = '{position: 3'b000, lat: LatAlu};
    end
    for (int i = 0; i < 2; i++) begin
      dst_addr[i]  = '0;
      lat_class[i] = LatAlu;
    end
  endtask

  // Slot0 reads one register (operand 0) whose scoreboard entry is supplied.
  task automatic consumer(input logic [4:0] r, input logic [2:0] pos, input lat_class_e lat);
    set_idle();
    inst_valid  = 2'b01;
    src_used    = 4'b0001;
    src_addr[0] = r;
    sb_data[0]  = '{position: pos, lat: lat};
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b0;
    consumer(5'd5, 3'b100, LatAlu);
    #1;
    check_eq("rst_issue", 32'(issue_ena), 32'h0);
    check_eq("rst_sbwe", 32'(sb_write_ena), 32'h0);
    check_eq("rst_dstall", 32'(decode_stall), 32'h1);
    check_eq("rst_fwd", 32'(fwd_sel[0]), 32'(FwdRf));
    next_cycle();
    rst_n = 1'b1;
    check_eq("rst_hcnt", 32'(hazard_cnt), 32'd0);

    // Load in EX: operand not ready yet.
    consumer(5'd5, 3'b100, LatLoad);
    #1;
    check_eq("ld_ex_issue", 32'(issue_ena), 32'h0);
    check_eq("ld_ex_dstall", 32'(decode_stall), 32'h1);
    next_cycle();
    check_eq("ld_ex_hcnt", 32'(hazard_cnt), 32'd1);
    consumer(5'd5, 3'b010, LatLoad);
    #1;
    check_eq("ld_mem_issue", 32'(issue_ena), 32'h1);
    check_eq("ld_mem_fwd", 32'(fwd_sel[0]), 32'(FwdWb));
    next_cycle();

    // Slot0 writes r3, slot1 reads r3 in the same pair.
    set_idle();
    inst_valid  = 2'b11;
    dst_ena     = 2'b01;
    dst_addr[0] = 5'd3;
    src_used    = 4'b0100;
    src_addr[2] = 5'd3;
    #1;
    check_eq("raw_issue", 32'(issue_ena), 32'h1);
    check_eq("raw_sbwe", 32'(sb_write_ena), 32'h1);
    check_eq("raw_sbwa", 32'(sb_write_addr[0]), 32'd3);
    check_eq("raw_sbwd", 32'(sb_write_data[0]), 32'b10000);
    next_cycle();
    set_idle();
    inst_valid  = 2'b11;
    src_used    = 4'b0101;
    src_addr[0] = 5'd0;
    sb_data[0]  = '{position: 3'b100, lat: LatLoad};
    src_addr[2] = 5'd3;
    sb_data[2]  = '{position: 3'b100, lat: LatAlu};
    #1;
    check_eq("fwd_mem_issue", 32'(issue_ena), 32'h3);
    check_eq("fwd_mem_sel", 32'(fwd_sel[2]), 32'(FwdMem));
    check_eq("r0_sel", 32'(fwd_sel[0]), 32'(FwdRf));
    check_eq("fwd_mem_hcnt", 32'(hazard_cnt), 32'd1);
    next_cycle();

    // Two LONG ops: only slot0 issues, FSM waits on r8.
    set_idle();
    inst_valid   = 2'b11;
    dst_ena      = 2'b11;
    dst_addr[0]  = 5'd8;
    dst_addr[1]  = 5'd9;
    lat_class[0] = LatLong;
    lat_class[1] = LatLong;
    #1;
    check_eq("long2_issue", 32'(issue_ena), 32'h1);
    check_eq("long2_sbwe", 32'(sb_write_ena), 32'h1);
    check_eq("long2_sbwd", 32'(sb_write_data[0]), 32'b10010);
    next_cycle();
    for (int i = 0; i < 4; i++) begin
      consumer(5'd8, 3'b000, LatAlu);
      #1;
      check_eq($sformatf("lw_stall%0d", i), 32'(issue_ena), 32'h0);
      next_cycle();
    end
    consumer(5'd8, 3'b000, LatAlu);
    long_done = 1'b1;
    #1;
    check_eq("lw_done_cyc", 32'(issue_ena), 32'h0);
    next_cycle();
    consumer(5'd8, 3'b000, LatAlu);
    #1;
    check_eq("lw_after_issue", 32'(issue_ena), 32'h1);
    check_eq("lw_after_fwd", 32'(fwd_sel[0]), 32'(FwdRf));
    check_eq("lw_after_hcnt", 32'(hazard_cnt), 32'd6);
    next_cycle();

    // long_done coinciding with a new LONG issue is ignored.
    set_idle();
    inst_valid   = 2'b01;
    dst_ena      = 2'b01;
    dst_addr[0]  = 5'd10;
    lat_class[0] = LatLong;
    long_done    = 1'b1;
    #1;
    check_eq("ign_issue", 32'(issue_ena), 32'h1);
    check_eq("ign_sbwe", 32'(sb_write_ena), 32'h1);
    next_cycle();
    consumer(5'd10, 3'b000, LatAlu);
    #1;
    check_eq("ign_still_wait", 32'(issue_ena), 32'h0);
    next_cycle();

    // long_done under pipe_stall is held until the stall clears.
    consumer(5'd10, 3'b000, LatAlu);
    pipe_stall = 1'b1;
    long_done  = 1'b1;
    #1;
    check_eq("ps_issue", 32'(issue_ena), 32'h0);
    check_eq("ps_dstall", 32'(decode_stall), 32'h1);
    next_cycle();
    consumer(5'd10, 3'b000, LatAlu);
    pipe_stall = 1'b1;
    #1;
    check_eq("ps_hcnt", 32'(hazard_cnt), 32'd7);
    next_cycle();
    consumer(5'd10, 3'b000, LatAlu);
    #1;
    check_eq("ps_release_wait", 32'(issue_ena), 32'h0);
    next_cycle();
    consumer(5'd10, 3'b000, LatAlu);
    #1;
    check_eq("ps_run_issue", 32'(issue_ena), 32'h1);
    check_eq("ps_run_hcnt", 32'(hazard_cnt), 32'd8);
    next_cycle();

    // Same destination in both slots.
    set_idle();
    inst_valid   = 2'b11;
    dst_ena      = 2'b11;
    dst_addr[0]  = 5'd7;
    dst_addr[1]  = 5'd7;
    lat_class[1] = LatLoad;
    #1;
    check_eq("waw_issue", 32'(issue_ena), 32'h3);
    check_eq("waw_sbwe", 32'(sb_write_ena), 32'h3);
    check_eq("waw_sbwa", 32'({sb_write_addr[1], sb_write_addr[0]}), 32'h0e7);
    check_eq("waw_sbwd1", 32'(sb_write_data[1]), 32'b10001);
    next_cycle();
    consumer(5'd7, 3'b000, LatAlu);
    sb_data[0] = sb_mem[7];
    #1;
    check_eq("waw_rd_lat", 32'(sb_data[0].lat), 32'(LatLoad));
    check_eq("waw_rd_issue", 32'(issue_ena), 32'h0);
    next_cycle();

    // Flush while waiting on a LONG op.
    set_idle();
    inst_valid   = 2'b01;
    dst_ena      = 2'b01;
    dst_addr[0]  = 5'd8;
    lat_class[0] = LatLong;
    #1;
    check_eq("fl_long_issue", 32'(issue_ena), 32'h1);
    check_eq("fl_pre_hcnt", 32'(hazard_cnt), 32'd9);
    next_cycle();
    set_idle();
    flash       = 1'b1;
    inst_valid  = 2'b11;
    dst_ena     = 2'b01;
    dst_addr[0] = 5'd4;
    #1;
    check_eq("fl_issue", 32'(issue_ena), 32'h0);
    check_eq("fl_sbwe", 32'(sb_write_ena), 32'h0);
    check_eq("fl_dstall", 32'(decode_stall), 32'h1);
    next_cycle();
    consumer(5'd8, 3'b000, LatAlu);
    #1;
    check_eq("fl_run_issue", 32'(issue_ena), 32'h1);
    check_eq("fl_hcnt_held", 32'(hazard_cnt), 32'd9);
    next_cycle();

    // Drive the counter to saturation.
    for (int i = 0; i < 7; i++) begin
      consumer(5'd5, 3'b100, LatLoad);
      #1;
      next_cycle();
    end
    check_eq("sat_hcnt", 32'(hazard_cnt), 32'd15);
    consumer(5'd5, 3'b100, LatLoad);
    flash = 1'b1;
    next_cycle();
    check_eq("sat_flash_hcnt", 32'(hazard_cnt), 32'd15);

    // Reset while a LONG op is outstanding; late long_done is ignored.
    set_idle();
    inst_valid   = 2'b01;
    dst_ena      = 2'b01;
    dst_addr[0]  = 5'd11;
    lat_class[0] = LatLong;
    next_cycle();
    rst_n = 1'b0;
    set_idle();
    next_cycle();
    rst_n = 1'b1;
    consumer(5'd11, 3'b000, LatAlu);
    long_done = 1'b1;
    #1;
    check_eq("rst_lw_hcnt", 32'(hazard_cnt), 32'd0);
    check_eq("rst_lw_issue", 32'(issue_ena), 32'h1);
    next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
